// File: rtl/action_exec_if.sv
// Packet handshake bundle between the stateful stage, action_exec and egress.
// The slave modport is the action_exec view; master is the driving/consuming side.
interface action_exec_if;
  logic         pkt_vld_in;
  logic [511:0] pkt_data_in;
  logic [15:0]  action_in;
  logic [7:0]   state_in;
  logic         pkt_vld_out;
  logic [511:0] pkt_data_out;
  logic [7:0]   port_out;
  logic         pkt_rdy_in;

  modport master (
    output pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
    input  pkt_vld_out, pkt_data_out, port_out
  );

  modport slave (
    input  pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
    output pkt_vld_out, pkt_data_out, port_out
  );
endinterface

// File: rtl/action_exec.sv
// Decodes the per-packet action, applies it to the header word and queues
// forwardable results in a small FIFO toward egress, counting drops and overflows.
module action_exec #(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] DEFAULT_PORT = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  action_exec_if.slave pkt_if,
  output logic [31:0]  fwd_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  ovf_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_FULL = FIFO_DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_FORWARD = 4'h0;
  localparam logic [3:0] OP_SETB    = 4'h2;
  localparam logic [3:0] OP_PORT    = 4'h3;

  logic [511:0] dec_data;
  logic [7:0]   dec_port;
  logic         dec_drop;

  logic         ex_vld;
  logic         ex_drop;
  logic [511:0] ex_data;
  logic [7:0]   ex_port;

  logic [511:0] mem_data [FIFO_DEPTH];
  logic [7:0]   mem_port [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic full;
  logic pop;
  logic push;

  // DROP and every unassigned opcode share the default branch.
  always_comb begin
    dec_data = pkt_if.pkt_data_in;
    dec_port = DEFAULT_PORT;
    dec_drop = 1'b0;
    case (pkt_if.action_in[15:12])
      OP_FORWARD: begin
      end
      OP_SETB:    dec_data[{pkt_if.action_in[5:0], 3'b000} +: 8] = pkt_if.state_in;
      OP_PORT:    dec_port = pkt_if.action_in[7:0];
      default:    dec_drop = 1'b1;
    endcase
  end

  assign full = (count == CNT_FULL);
  assign pop  = (count != '0) && pkt_if.pkt_rdy_in;
  assign push = ex_vld && !ex_drop && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_vld   <= 1'b0;
      ex_drop  <= 1'b0;
      ex_data  <= '0;
      ex_port  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fwd_cnt  <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      ex_vld <= pkt_if.pkt_vld_in;
      if (pkt_if.pkt_vld_in) begin
        ex_drop <= dec_drop;
        ex_data <= dec_data;
        ex_port <= dec_port;
      end
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ex_vld && ex_drop)
        drop_cnt <= drop_cnt + 32'd1;
      if (push)
        fwd_cnt <= fwd_cnt + 32'd1;
      if (ex_vld && !ex_drop && !push)
        ovf_cnt <= ovf_cnt + 32'd1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= ex_data;
      mem_port[wr_ptr] <= ex_port;
    end
  end

  assign pkt_if.pkt_vld_out  = (count != '0);
  assign pkt_if.pkt_data_out = pkt_if.pkt_vld_out ? mem_data[rd_ptr] : '0;
  assign pkt_if.port_out     = pkt_if.pkt_vld_out ? mem_port[rd_ptr] : '0;

endmodule

// File: tb/tb_action_exec.sv
// Bench for action_exec: a queue-based model tracks the expected FIFO contents
// and counters, checked every cycle, plus directed literal scenarios and random traffic.
module tb_action_exec;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] ovf_cnt;

  action_exec_if ifc ();

  action_exec #(.FIFO_DEPTH(DEPTH), .DEFAULT_PORT(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .pkt_if   (ifc.slave),
    .fwd_cnt  (fwd_cnt),
    .drop_cnt (drop_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [511:0] q_data [$];
  logic [7:0]   q_port [$];
  logic [31:0]  m_fwd, m_drop, m_ovf;
  logic         pend_vld, pend_drop;
  logic [511:0] pend_data;
  logic [7:0]   pend_port;
  logic         model_ready = 1'b0;
  logic         m_pop;

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-array view of the header: SETB overwrites one whole byte slot.
  function automatic void model_decode(input logic [511:0] d, input logic [15:0] a,
                                       input logic [7:0] s, output logic drop,
                                       output logic [511:0] od, output logic [7:0] op);
    logic [7:0] bytes [64];
    for (int i = 0; i < 64; i++) bytes[i] = d[i*8 +: 8];
    drop = 1'b0;
    op   = 8'h00;
    case (a[15:12])
      4'h0: begin
      end
      4'h2: bytes[a[5:0]] = s;
      4'h3: op = a[7:0];
      default: drop = 1'b1;
    endcase
    for (int i = 0; i < 64; i++) od[i*8 +: 8] = bytes[i];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      q_data.delete();
      q_port.delete();
      m_fwd = 0; m_drop = 0; m_ovf = 0;
      pend_vld = 1'b0;
    end else begin
      m_pop = (q_data.size() != 0) && ifc.pkt_rdy_in;
      if (m_pop) begin
        void'(q_data.pop_front());
        void'(q_port.pop_front());
      end
      if (pend_vld) begin
        if (pend_drop) m_drop = m_drop + 1;
        else if (q_data.size() < DEPTH) begin
          q_data.push_back(pend_data);
          q_port.push_back(pend_port);
          m_fwd = m_fwd + 1;
        end else m_ovf = m_ovf + 1;
      end
      pend_vld = ifc.pkt_vld_in;
      if (pend_vld)
        model_decode(ifc.pkt_data_in, ifc.action_in, ifc.state_in, pend_drop, pend_data, pend_port);
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check_output("vld_out", {511'd0, ifc.pkt_vld_out}, {511'd0, q_data.size() != 0});
      check_output("data_out", ifc.pkt_data_out, (q_data.size() != 0) ? q_data[0] : 512'd0);
      check_output("port_out", {504'd0, ifc.port_out}, {504'd0, (q_port.size() != 0) ? q_port[0] : 8'h00});
      check_output("fwd_cnt", {480'd0, fwd_cnt}, {480'd0, m_fwd});
      check_output("drop_cnt", {480'd0, drop_cnt}, {480'd0, m_drop});
      check_output("ovf_cnt", {480'd0, ovf_cnt}, {480'd0, m_ovf});
    end
  end

  task automatic apply_stimulus(input logic vld, input logic [511:0] data, input logic [15:0] act,
                                input logic [7:0] st, input logic rdy);
    ifc.pkt_vld_in  = vld;
    ifc.pkt_data_in = data;
    ifc.action_in   = act;
    ifc.state_in    = st;
    ifc.pkt_rdy_in  = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 512'h77, 16'h0000, 8'h00, 1'b1);
    reset = 1'b1;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  logic [511:0] lit;
  logic [3:0]   op;
  logic [15:0]  act;
  int           rdy_pct;

  initial begin
    reset = 1'b0;
    ifc.pkt_vld_in = 1'b0; ifc.pkt_data_in = '0; ifc.action_in = '0;
    ifc.state_in = '0; ifc.pkt_rdy_in = 1'b0;

    // Reset held with traffic present; nothing may leak out afterwards.
    do_reset(3);
    check_output("rst_vld", {511'd0, ifc.pkt_vld_out}, 512'd0);
    check_output("rst_data", ifc.pkt_data_out, 512'd0);
    check_output("rst_fwd", {480'd0, fwd_cnt}, 512'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
      check_output("idle_vld", {511'd0, ifc.pkt_vld_out}, 512'd0);
    end

    // Plain forward with two-cycle latency.
    apply_stimulus(1'b1, 512'h4329, 16'h0000, 8'h00, 1'b1);
    check_output("fwd_lat_vld", {511'd0, ifc.pkt_vld_out}, 512'd0);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    check_output("fwd_vld", {511'd0, ifc.pkt_vld_out}, 512'd1);
    check_output("fwd_data", ifc.pkt_data_out, 512'h4329);
    check_output("fwd_port", {504'd0, ifc.port_out}, 512'd0);
    check_output("fwd_cnt1", {480'd0, fwd_cnt}, 512'd1);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    check_output("fwd_done", {511'd0, ifc.pkt_vld_out}, 512'd0);

    // Byte rewrite at the low end and at the top byte.
    do_reset(1);
    apply_stimulus(1'b1, 512'h4329, 16'h2001, 8'hAB, 1'b1);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    check_output("setb1", ifc.pkt_data_out, 512'hAB29);
    apply_stimulus(1'b1, 512'h4329, 16'h203F, 8'h5A, 1'b1);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    lit = 512'h4329;
    lit[511:504] = 8'h5A;
    check_output("setb63", ifc.pkt_data_out, lit);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);

    // Drop, port select, bad opcode.
    do_reset(1);
    apply_stimulus(1'b1, 512'h11, 16'h1000, 8'h00, 1'b1);
    apply_stimulus(1'b1, 512'h22, 16'h3007, 8'h00, 1'b1);
    apply_stimulus(1'b1, 512'h33, 16'h9000, 8'h00, 1'b1);
    check_output("port_vld", {511'd0, ifc.pkt_vld_out}, 512'd1);
    check_output("port_sel", {504'd0, ifc.port_out}, 512'h07);
    check_output("port_data", ifc.pkt_data_out, 512'h22);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    check_output("drop_cnt2", {480'd0, drop_cnt}, 512'd2);
    check_output("drop_fwd1", {480'd0, fwd_cnt}, 512'd1);
    check_output("drop_vld", {511'd0, ifc.pkt_vld_out}, 512'd0);

    // Overflow with egress stalled, then in-order drain.
    do_reset(1);
    for (int i = 1; i <= 6; i++) apply_stimulus(1'b1, 512'(i), 16'h0000, 8'h00, 1'b0);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b0);
    check_output("ovf_cnt2", {480'd0, ovf_cnt}, 512'd2);
    check_output("ovf_fwd4", {480'd0, fwd_cnt}, 512'd4);
    for (int i = 1; i <= 4; i++) begin
      check_output("drain_vld", {511'd0, ifc.pkt_vld_out}, 512'd1);
      check_output("drain_data", ifc.pkt_data_out, 512'(i));
      apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    end
    check_output("drain_empty", {511'd0, ifc.pkt_vld_out}, 512'd0);

    // Push into a full FIFO on the same edge as a pop, then reset mid-drain.
    do_reset(1);
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 512'(i), 16'h0000, 8'h00, 1'b0);
    apply_stimulus(1'b1, 512'h55, 16'h0000, 8'h00, 1'b0);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    check_output("full_ovf0", {480'd0, ovf_cnt}, 512'd0);
    check_output("full_fwd5", {480'd0, fwd_cnt}, 512'd5);
    check_output("full_head2", ifc.pkt_data_out, 512'h2);
    apply_stimulus(1'b0, 512'h0, 16'h0, 8'h0, 1'b1);
    check_output("full_head3", ifc.pkt_data_out, 512'h3);
    do_reset(1);
    check_output("midrst_vld", {511'd0, ifc.pkt_vld_out}, 512'd0);
    check_output("midrst_fwd", {480'd0, fwd_cnt}, 512'd0);
    check_output("midrst_port", {504'd0, ifc.port_out}, 512'd0);

    // Random traffic with varying egress pressure and rare resets.
    rdy_pct = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) rdy_pct = $urandom_range(10, 100);
      if ($urandom_range(0, 499) == 0) do_reset(1);
      op = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      act = {op, 12'($urandom)};
      apply_stimulus($urandom_range(0, 3) != 0, rand_data(), act, 8'($urandom),
                     $urandom_range(1, 100) <= rdy_pct);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
